// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract engine: resolves DIGIT bits per clock through a
// rippled full-adder chain, with the carry registered between digits.
module serial_addsub_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_sum;
  logic [WIDTH-1:0] w_res_nxt;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(N - 1));

  // Ripple chain over the DIGIT least-significant bits of the shifting operands
  always_comb begin
    w_c    = '0;
    w_sum  = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      w_sum[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
      w_c[i + 1] = (r_a[i] & r_b[i]) | (r_b[i] & w_c[i]) | (r_a[i] & w_c[i]);
    end
  end

  // New sum digit enters at the MSB end; after N digits the word is aligned
  assign w_res_nxt = WIDTH'({w_sum, r_res} >> DIGIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtract as A + ~B + (1 - cin)
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_c[DIGIT];
      r_res   <= w_res_nxt;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_s    <= w_res_nxt;
        r_cout <= w_c[DIGIT];
        r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit: 8-bit/1-digit, 16-bit/4-digit and
// 16-bit/16-digit instances checked against hand-computed results.
module tb_serial_addsub_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, s8;
  logic        rstq, startq, cinq, subq, busyq, doneq, coutq, ovfq;
  logic [15:0] aq, bq, sq;
  logic        rstw, startw, cinw, subw, busyw, donew, coutw, ovfw;
  logic [15:0] aw, bw, sw;

  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) u_d8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d16q (
    .clk(clk), .rst(rstq), .start(startq), .a(aq), .b(bq), .cin(cinq), .sub(subq),
    .busy(busyq), .done(doneq), .s(sq), .cout(coutq), .ovf(ovfq));

  serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16w (
    .clk(clk), .rst(rstw), .start(startw), .a(aw), .b(bw), .cin(cinw), .sub(subw),
    .busy(busyw), .done(donew), .s(sw), .cout(coutw), .ovf(ovfw));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents one operation and returns #1 after the accepting edge
  task automatic start_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                           input logic tsub);
    @(negedge clk);
    a8 = ta; b8 = tb_; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = busy8 ? 1 : 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy8 === 1'b1) busy_n++;
    end
  endtask

  int cyc, bn, dn;

  initial begin
    vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[3] = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    rstq = 1'b1; startq = 1'b0; aq = '0; bq = '0; cinq = 1'b0; subq = 1'b0;
    rstw = 1'b1; startw = 1'b0; aw = '0; bw = '0; cinw = 1'b0; subw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'h0);
    check("rst_done8", 32'(done8), 32'h0);
    check("rst_s8",    32'(s8),    32'h0);
    check("rst_cout8", 32'(cout8), 32'h0);
    check("rst_ovf8",  32'(ovf8),  32'h0);
    check("rst_sq",    32'(sq),    32'h0);
    check("rst_sw",    32'(sw),    32'h0);
    @(negedge clk);
    rst8 = 1'b0; rstq = 1'b0; rstw = 1'b0;

    // Table: each vector checked for latency, busy length, results and single-cycle done
    for (int i = 0; i < NV; i++) begin
      start_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done8(cyc, bn);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'd8);
      check($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'd8);
      check($sformatf("v%0d_s", i), 32'(s8), 32'(vecs[i].s));
      check($sformatf("v%0d_cout", i), 32'(cout8), 32'(vecs[i].cout));
      check($sformatf("v%0d_ovf", i), 32'(ovf8), 32'(vecs[i].ovf));
      if (i == NV - 1) begin
        // Back-to-back start in the done cycle of the last vector
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("b2b_busy", 32'(busy8), 32'h1);
        check("b2b_s_hold", 32'(s8), 32'h00);
        wait_done8(cyc, bn);
        check("b2b_gap", 32'(cyc + 1), 32'd9);
        check("b2b_s", 32'(s8), 32'h30);
      end else begin
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", i), 32'(done8), 32'h0);
      end
    end

    // Start during RUN must be ignored and s must hold until completion
    start_op8(8'h03, 8'h04, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy_prot_s_hold", 32'(s8), 32'h30);
    wait_done8(cyc, bn);
    check("busy_prot_latency", 32'(cyc), 32'd5);
    check("busy_prot_s", 32'(s8), 32'h07);
    dn = 0;
    repeat (20) begin @(posedge clk); #1; if (done8 === 1'b1) dn++; end
    check("busy_prot_single_done", 32'(dn), 32'h0);

    // Asynchronous reset between edges mid-operation
    start_op8(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst8 = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy8), 32'h0);
    check("mid_rst_done", 32'(done8), 32'h0);
    check("mid_rst_s",    32'(s8),    32'h0);
    check("mid_rst_cout", 32'(cout8), 32'h0);
    check("mid_rst_ovf",  32'(ovf8),  32'h0);
    @(negedge clk);
    rst8 = 1'b0;
    dn = 0;
    repeat (15) begin @(posedge clk); #1; if (done8 === 1'b1 || busy8 === 1'b1) dn++; end
    check("mid_rst_no_done", 32'(dn), 32'h0);
    start_op8(8'h11, 8'h22, 1'b0, 1'b0);
    wait_done8(cyc, bn);
    check("post_rst_latency", 32'(cyc), 32'd8);
    check("post_rst_s", 32'(s8), 32'h33);

    // WIDTH=16, DIGIT=4
    @(negedge clk);
    aq = 16'hFFFF; bq = 16'h0001; cinq = 1'b0; subq = 1'b0; startq = 1'b1;
    @(posedge clk); #1;
    startq = 1'b0;
    cyc = 0;
    while (doneq !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("d4_latency", 32'(cyc), 32'd4);
    check("d4_s", 32'(sq), 32'h0000);
    check("d4_cout", 32'(coutq), 32'h1);
    check("d4_ovf", 32'(ovfq), 32'h0);

    // WIDTH=16, DIGIT=16
    @(negedge clk);
    aw = 16'h8000; bw = 16'h8000; cinw = 1'b0; subw = 1'b0; startw = 1'b1;
    @(posedge clk); #1;
    startw = 1'b0;
    check("d16_busy", 32'(busyw), 32'h1);
    cyc = 0;
    while (donew !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("d16_latency", 32'(cyc), 32'd1);
    check("d16_s", 32'(sw), 32'h0000);
    check("d16_cout", 32'(coutw), 32'h1);
    check("d16_ovf", 32'(ovfw), 32'h1);
    @(posedge clk); #1;
    check("d16_done_pulse", 32'(donew), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
